csa_resolve: RTL

Multi-cycle carry-propagate resolver that converts a carry-save pair (sum, carry vectors from the team's 3:2 carry-save stage) back into a single binary result. It sits downstream of the carry-save compressor tree. It ripples the final addition over K-bit slices, one slice per clock, so the wide carry chain never sits in one cycle. Valid/ready handshakes on both sides let it sit between pipelined producers and consumers.

---
 rtl/csa_resolve_if.sv | 12 +
 rtl/csa_resolve.sv | 57 +++++
 2 files changed

// File: rtl/csa_resolve_if.sv
// csa_resolve_if: valid/ready carry-save input and binary result output bundle
interface csa_resolve_if #(parameter int N = 16);
   logic in_valid;
   logic in_ready;
   logic [N-1:0] sum;
   logic [N-1:0] carry;
   logic out_valid;
   logic out_ready;
   logic [N+1:0] result;
   modport master (output in_valid, sum, carry, out_ready, input in_ready, out_valid, result);
   modport slave (input in_valid, sum, carry, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/csa_resolve.sv
// csa_resolve: resolves a carry-save pair into sum + 2*carry, rippling K bits per clock
module csa_resolve #(
   parameter int N = 16,
   parameter int K = 4
) (
   input logic clk,
   input logic rst_n,
   csa_resolve_if.slave bus
);
   localparam int S = N / K;
   localparam int JW = S > 1 ? $clog2(S) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [N-1:0] a;
   logic [N:0] b;
   logic cin;
   logic [JW-1:0] j;
   logic [K:0] slc;
   assign bus.in_ready = state == IDLE;
   assign slc = {1'b0, a[int'(j)*K +: K]} + {1'b0, b[int'(j)*K +: K]} + (K+1)'(cin);
   // b holds carry pre-shifted by one; b[N] only enters the top two result bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a <= '0;
         b <= '0;
         cin <= 1'b0;
         j <= '0;
         bus.result <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a <= bus.sum;
               b <= {bus.carry, 1'b0};
               cin <= 1'b0;
               j <= '0;
               state <= RUN;
            end
            RUN: begin
               bus.result[int'(j)*K +: K] <= slc[K-1:0];
               cin <= slc[K];
               if (j == JW'(S - 1)) begin
                  bus.result[N+1:N] <= {1'b0, b[N]} + {1'b0, slc[K]};
                  bus.out_valid <= 1'b1;
                  state <= DONE;
               end else j <= j + 1'b1;
            end
            DONE: if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
